// File: rtl/counter_delta_sampler_if.sv
// Stream and status bundle for counter_delta_sampler: the sample/count input side,
// the val/rdy delta output stream and the overflow/occupancy status.
interface counter_delta_sampler_if #(
  parameter int DEPTH = 4
);
  logic                     sample;
  logic [31:0]              count_in;
  logic                     ostream_val;
  logic                     ostream_rdy;
  logic [31:0]              ostream_msg;
  logic                     overflow;
  logic [$clog2(DEPTH):0]   occupancy;

  // master: the sampler itself; slave: the environment driving samples and consuming deltas
  modport master (
    input  sample, count_in, ostream_rdy,
    output ostream_val, ostream_msg, overflow, occupancy
  );

  modport slave (
    output sample, count_in, ostream_rdy,
    input  ostream_val, ostream_msg, overflow, occupancy
  );
endinterface

// File: rtl/counter_delta_sampler.sv
// Captures the free-running event counter on each sample strobe and queues the modulo-2^32
// delta since the last accepted sample. Optional macro: COUNTER_DELTA_SAMPLER_BYPASS_EN.
module counter_delta_sampler #(
  parameter int DEPTH = 4
) (
  input logic                     clk,
  input logic                     reset,
  counter_delta_sampler_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [OCC_W-1:0] occ;
  logic [31:0]      prev;
  logic             overflow_q;

  logic [31:0]      delta;
  logic             fifo_val;
  logic             full;
  logic             pop;
  logic             accept;
  logic             bypass;
  logic             push;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    delta    = bus.count_in - prev;
    fifo_val = (occ != '0);
    full     = (occ == OCC_W'(DEPTH));
    pop      = fifo_val && bus.ostream_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    accept   = bus.sample && !reset && (!full || pop);
`ifdef COUNTER_DELTA_SAMPLER_BYPASS_EN
    bypass   = bus.sample && !reset && !fifo_val && bus.ostream_rdy;
`else
    bypass   = 1'b0;
`endif
    push     = accept && !bypass;
  end

`ifdef COUNTER_DELTA_SAMPLER_BYPASS_EN
  // Comb path sample -> ostream_val/msg when the FIFO is empty and the consumer is ready.
  assign bus.ostream_val = fifo_val || bypass;
  assign bus.ostream_msg = bypass ? delta : mem[rd_ptr];
`else
  assign bus.ostream_val = fifo_val;
  assign bus.ostream_msg = mem[rd_ptr];
`endif

  assign bus.overflow  = overflow_q;
  assign bus.occupancy = occ;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ        <= '0;
      prev       <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) prev <= bus.count_in;
      if (bus.sample && !accept) overflow_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and occupancy alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= delta;
  end

endmodule
